uart_fifo: RTL and testbench
============================

# uart_fifo

Buffered CPU-side front end for the board UART (`buart`). It holds two DEPTH-entry FIFOs:
- The TX FIFO accepts bytes from the CPU I/O port and drains them into the transmitter's `wr`/`tx_data` strobe, one byte each time the transmitter is idle.
- The RX FIFO pulls completed characters out of the receiver using `valid`/`rd` and presents them to the CPU as a show-ahead queue.

The block sits between the J1 I/O decode and `buart`, so the CPU no longer has to poll per character.

## Interface
Parameters:
- DEPTH, 16, entries per FIFO; power of two, ≥2. AW = log2(DEPTH).

Ports:
- clk  in  1  system clock.
- resetq  in  1  reset, asynchronous, active-low.
- tx_wr  in  1  CPU push strobe for the TX FIFO.
- tx_data  in  8  byte to push.
- tx_full  out  1  TX FIFO holds DEPTH entries.
- tx_level  out  AW+1  TX FIFO occupancy, 0..DEPTH.
- rx_rd  in  1  CPU pop strobe for the RX FIFO.
- rx_data  out  8  head of the RX FIFO; undefined while rx_valid=0.
- rx_valid  out  1  RX FIFO is non-empty.
- rx_level  out  AW+1  RX FIFO occupancy.
- err_tx_ovf  out  1  sticky: tx_wr seen while tx_full.
- err_rx_udf  out  1  sticky: rx_rd seen while !rx_valid.
- clr_err  in  1  clears both sticky flags.
- u_wr  out  1  registered transmit strobe to `buart.wr`.
- u_tx_data  out  8  registered byte to `buart.tx_data`.
- u_busy  in  1  from `buart.busy`.
- u_rd  out  1  registered read strobe to `buart.rd`.
- u_valid  in  1  from `buart.valid`.
- u_rx_data  in  8  from `buart.rx_data`.

## Operation
- **FIFO storage**
  - Each FIFO is a DEPTH×8 array with AW-bit read and write pointers that wrap modulo DEPTH, plus an (AW+1)-bit count.
  - Full means count==DEPTH; empty means count==0. The array itself is not reset.
- **TX push**
  - tx_wr && !tx_full writes tx_data and increments the write pointer.
  - tx_wr && tx_full drops the byte and sets err_tx_ovf.
  - Full is evaluated at the start of the cycle, so a push while full is dropped even if the drain pops in that same cycle.
- **TX drain FSM** (T_IDLE, T_SENT, T_SETTLE):
  - T_IDLE: if TX non-empty && !u_busy, then at the edge u_wr←1, u_tx_data←head, the FIFO pops, and the FSM moves to T_SENT. Otherwise u_wr←0.
  - T_SENT: u_wr←0, move to T_SETTLE. This cycle covers the latency before u_busy rises, which is one cycle after u_wr.
  - T_SETTLE: move to T_IDLE.
- **RX FIFO push**
  - The RX FIFO is filled only by the RX fill FSM below.
  - If the RX FIFO is full, the byte stays in `buart` with u_valid held, and the FSM waits. Characters arriving on the wire meanwhile are lost inside the receiver; this block does not flag it.
- **RX fill FSM** (R_IDLE, R_ACK, R_SETTLE):
  - R_IDLE: if u_valid && RX not full, push u_rx_data, u_rd←1, and move to R_ACK.
  - R_ACK: u_rd←0, move to R_SETTLE. u_valid is still high during this cycle and must be ignored.
  - R_SETTLE: move to R_IDLE.
- **RX pop**
  - rx_rd && rx_valid advances the read pointer.
  - rx_rd && !rx_valid has no effect on the FIFO and sets err_rx_udf.
- **Simultaneous events**
  - Push and pop in the same cycle on one FIFO: both take effect and the count is unchanged.
  - Pop from a full FIFO plus push: the push is accepted only if not full at the start of the cycle.
  - clr_err together with a new error event: the set wins.
- **Reset mid-operation**: all pointers and counts →0, FSMs → IDLE, strobes →0, flags →0. Bytes in flight are discarded.

## Timing
- Reset values:
  - tx_full=0, tx_level=0.
  - rx_valid=0, rx_level=0.
  - err flags 0.
  - u_wr=0, u_tx_data=8'h00, u_rd=0.
- All outputs are registered or derived directly from registered counts.
- TX: a CPU push in cycle N into an empty FIFO with u_busy=0 gives u_wr=1 in cycle N+2: cycle N+1 sees non-empty in T_IDLE, and the strobe is registered at the end of N+1.
- u_wr is always a single-cycle pulse, with at least 2 low cycles between pulses.
- RX: u_valid rising in cycle M (FIFO not full) gives rx_valid=1 and u_rd=1 in cycle M+1. rx_data equals u_rx_data sampled in M.
- u_rd is always a single-cycle pulse, with at least 2 low cycles between pulses. Each u_valid episode yields exactly one push.
- tx_level and rx_level update the cycle after the push/pop edge.

## Test plan
- **Reset:** assert resetq=0 mid-transfer with 5 bytes in each FIFO → all outputs at reset values while low; after release, tx_level=0, rx_valid=0, u_wr stays 0.
- **TX ordering:** push 0x41,0x42,0x43 back-to-back with the `buart` model → exactly 3 u_wr pulses carrying 0x41,0x42,0x43 in order; each issued only after u_busy falls; the wire decodes "ABC".
- **TX overflow:** with u_busy forced 1, push DEPTH+1 bytes → tx_full=1, tx_level=DEPTH, err_tx_ovf=1; the extra byte never appears; clr_err → flag 0.
- **RX fill/drain:** inject 0x55 then 0xAA on the serial line → rx_level=2, rx_data=0x55; rx_rd → rx_data=0xAA; rx_rd → rx_valid=0; exactly one u_rd pulse per character.
- **RX full hold:** fill the RX FIFO to DEPTH, then inject 0x7E → u_valid stays 1 and no u_rd; one rx_rd → within 3 cycles u_rd pulses and 0x7E lands at the tail; rx_level=DEPTH.
- **Simultaneous push/pop and underflow:** rx_rd on an empty FIFO → err_rx_udf=1, pointers unchanged. Same-cycle CPU pop and fill push at level 3 → level stays 3 and data order is preserved.

Source files
------------

// File: rtl/uart_fifo.sv
// uart_fifo: buffered TX/RX byte queues between the CPU I/O port and the buart transmitter/receiver
module uart_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetq,
  input  logic          tx_wr,
  input  logic [7:0]    tx_data,
  output logic          tx_full,
  output logic [AW:0]   tx_level,
  input  logic          rx_rd,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  output logic [AW:0]   rx_level,
  output logic          err_tx_ovf,
  output logic          err_rx_udf,
  input  logic          clr_err,
  output logic          u_wr,
  output logic [7:0]    u_tx_data,
  input  logic          u_busy,
  output logic          u_rd,
  input  logic          u_valid,
  input  logic [7:0]    u_rx_data
);
  localparam logic [1:0] T_IDLE = 2'd0, T_SENT = 2'd1, T_SETTLE = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_ACK = 2'd1, R_SETTLE = 2'd2;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [AW:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [1:0] ts_q, ts_d, rs_q, rs_d;
  logic u_wr_q, u_wr_d, u_rd_q, u_rd_d;
  logic [7:0] u_tx_data_q, u_tx_data_d;
  logic err_tx_ovf_q, err_tx_ovf_d, err_rx_udf_q, err_rx_udf_d;
  logic tx_push, tx_pop, rx_push, rx_pop;

  assign tx_full    = tx_cnt_q == FULL;
  assign tx_level   = tx_cnt_q;
  assign rx_valid   = rx_cnt_q != '0;
  assign rx_level   = rx_cnt_q;
  assign rx_data    = rx_mem[rx_rp_q];
  assign err_tx_ovf = err_tx_ovf_q;
  assign err_rx_udf = err_rx_udf_q;
  assign u_wr       = u_wr_q;
  assign u_tx_data  = u_tx_data_q;
  assign u_rd       = u_rd_q;

  always_comb begin
    tx_push      = tx_wr && !tx_full;
    tx_pop       = ts_q == T_IDLE && tx_cnt_q != '0 && !u_busy;
    // u_valid stays high through R_ACK, so only R_IDLE may accept a character
    rx_push      = rs_q == R_IDLE && u_valid && rx_cnt_q != FULL;
    rx_pop       = rx_rd && rx_valid;
    tx_wp_d      = tx_push ? tx_wp_q + AW'(1) : tx_wp_q;
    tx_rp_d      = tx_pop ? tx_rp_q + AW'(1) : tx_rp_q;
    tx_cnt_d     = tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    rx_wp_d      = rx_push ? rx_wp_q + AW'(1) : rx_wp_q;
    rx_rp_d      = rx_pop ? rx_rp_q + AW'(1) : rx_rp_q;
    rx_cnt_d     = rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    ts_d         = ts_q == T_IDLE ? (tx_pop ? T_SENT : T_IDLE) : ts_q == T_SENT ? T_SETTLE : T_IDLE;
    rs_d         = rs_q == R_IDLE ? (rx_push ? R_ACK : R_IDLE) : rs_q == R_ACK ? R_SETTLE : R_IDLE;
    u_wr_d       = tx_pop;
    u_tx_data_d  = tx_pop ? tx_mem[tx_rp_q] : u_tx_data_q;
    u_rd_d       = rx_push;
    err_tx_ovf_d = (tx_wr && tx_full) || (err_tx_ovf_q && !clr_err);
    err_rx_udf_d = (rx_rd && !rx_valid) || (err_rx_udf_q && !clr_err);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= tx_data;
    if (rx_push) rx_mem[rx_wp_q] <= u_rx_data;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_wp_q      <= '0;
      tx_rp_q      <= '0;
      tx_cnt_q     <= '0;
      rx_wp_q      <= '0;
      rx_rp_q      <= '0;
      rx_cnt_q     <= '0;
      ts_q         <= T_IDLE;
      rs_q         <= R_IDLE;
      u_wr_q       <= 1'b0;
      u_tx_data_q  <= 8'h00;
      u_rd_q       <= 1'b0;
      err_tx_ovf_q <= 1'b0;
      err_rx_udf_q <= 1'b0;
    end else begin
      tx_wp_q      <= tx_wp_d;
      tx_rp_q      <= tx_rp_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_wp_q      <= rx_wp_d;
      rx_rp_q      <= rx_rp_d;
      rx_cnt_q     <= rx_cnt_d;
      ts_q         <= ts_d;
      rs_q         <= rs_d;
      u_wr_q       <= u_wr_d;
      u_tx_data_q  <= u_tx_data_d;
      u_rd_q       <= u_rd_d;
      err_tx_ovf_q <= err_tx_ovf_d;
      err_rx_udf_q <= err_rx_udf_d;
    end
  end
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: scoreboard bench for uart_fifo with a small behavioural buart model
module tb_uart_fifo;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int BUSY = 4;
  logic clk = 0, resetq = 0, tx_wr = 0, rx_rd = 0, clr_err = 0;
  logic [7:0] tx_data = 0;
  logic tx_full, rx_valid, err_tx_ovf, err_rx_udf, u_wr, u_rd;
  logic [AW:0] tx_level, rx_level;
  logic [7:0] rx_data, u_tx_data;
  logic u_busy, force_busy = 0;
  logic u_valid = 0;
  logic [7:0] u_rx_data = 0;
  int busy_cnt = 0, busy_pend = 0, wr_low = 100, rd_low = 100;
  int tx_obs_n = 0, rd_pulses = 0, busy_bad = 0, gap_bad = 0;
  int inj_req = 0, inj_done = 0;
  logic [7:0] tx_obs [64];
  logic [7:0] inj_buf [64];
  logic [7:0] tx_exp [$];
  logic [7:0] rx_exp [$];
  int n_cmp = 0, n_bad = 0;

  assign u_busy = force_busy || busy_cnt != 0;

  uart_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetq(resetq), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .tx_level(tx_level), .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_level(rx_level), .err_tx_ovf(err_tx_ovf), .err_rx_udf(err_rx_udf), .clr_err(clr_err),
    .u_wr(u_wr), .u_tx_data(u_tx_data), .u_busy(u_busy), .u_rd(u_rd), .u_valid(u_valid),
    .u_rx_data(u_rx_data)
  );

  always #5 clk = ~clk;

  // buart stand-in: busy rises the cycle after wr, valid drops the cycle rd is seen
  always @(negedge clk) begin
    if (!resetq) begin
      u_valid   <= 0;
      busy_cnt  <= 0;
      busy_pend <= 0;
      inj_done  <= inj_req;
    end else begin
      if (u_wr) begin
        tx_obs[tx_obs_n] <= u_tx_data;
        tx_obs_n <= tx_obs_n + 1;
        if (u_busy) busy_bad <= busy_bad + 1;
        if (wr_low < 2) gap_bad <= gap_bad + 1;
        busy_pend <= 1;
        wr_low <= 0;
      end else begin
        wr_low <= wr_low + 1;
        if (busy_pend != 0) begin
          busy_pend <= 0;
          busy_cnt <= BUSY;
        end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      end
      if (u_rd) begin
        rd_pulses <= rd_pulses + 1;
        if (rd_low < 2) gap_bad <= gap_bad + 1;
        u_valid <= 0;
        rd_low <= 0;
      end else begin
        rd_low <= rd_low + 1;
        if (!u_valid && inj_done != inj_req) begin
          u_valid <= 1;
          u_rx_data <= inj_buf[inj_done];
          inj_done <= inj_done + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b, input bit keep);
    tx_wr = 1;
    tx_data = b;
    if (keep) tx_exp.push_back(b);
    tick();
    tx_wr = 0;
  endtask

  task automatic inject(input logic [7:0] b, input bit keep);
    inj_buf[inj_req] = b;
    inj_req++;
    if (keep) rx_exp.push_back(b);
  endtask

  task automatic cpu_pop(input string tag);
    chk(tag, rx_data, rx_exp.pop_front());
    rx_rd = 1;
    tick();
    rx_rd = 0;
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 2000 && tx_obs_n < n; i++) tick();
    chk("tx_count", tx_obs_n, n);
  endtask

  task automatic cmp_tx(input int from, input int n);
    for (int i = 0; i < n; i++) chk("tx_byte", tx_obs[from+i], tx_exp.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, rd_base;
    tick(2);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_errs", {err_tx_ovf, err_rx_udf}, 0);
    chk("rst_strobes", {u_wr, u_rd, u_tx_data}, 0);
    resetq = 1;
    tick(2);
    base = tx_obs_n;
    push_tx(8'h41, 1);
    chk("tx_lat_n1", u_wr, 0);
    tick();
    chk("tx_lat_n2", u_wr, 1);
    chk("tx_lat_data", u_tx_data, 8'h41);
    push_tx(8'h42, 1);
    push_tx(8'h43, 1);
    wait_tx(base + 3);
    cmp_tx(base, 3);
    tick(20);
    chk("tx_exact3", tx_obs_n - base, 3);
    force_busy = 1;
    base = tx_obs_n;
    for (int i = 0; i < DEPTH; i++) push_tx(8'h80 + 8'(i), 1);
    push_tx(8'hEE, 0);
    chk("ovf_full", tx_full, 1);
    chk("ovf_level", tx_level, DEPTH);
    chk("ovf_flag", err_tx_ovf, 1);
    clr_err = 1;
    push_tx(8'hEE, 0);
    clr_err = 0;
    chk("ovf_set_wins", err_tx_ovf, 1);
    chk("ovf_level2", tx_level, DEPTH);
    clr_err = 1;
    tick();
    clr_err = 0;
    chk("ovf_clr", err_tx_ovf, 0);
    force_busy = 0;
    wait_tx(base + DEPTH);
    cmp_tx(base, DEPTH);
    tick(20);
    chk("ovf_no_extra", tx_obs_n - base, DEPTH);
    chk("tx_drained", tx_level, 0);
    rd_base = rd_pulses;
    inject(8'h55, 1);
    tick();
    chk("rx_lat_valid", rx_valid, 1);
    chk("rx_lat_urd", u_rd, 1);
    chk("rx_lat_data", rx_data, 8'h55);
    inject(8'hAA, 1);
    tick(10);
    chk("rx_level2", rx_level, 2);
    chk("rx_one_rd_each", rd_pulses - rd_base, 2);
    cpu_pop("rx_head0");
    cpu_pop("rx_head1");
    chk("rx_empty", rx_valid, 0);
    rx_rd = 1;
    tick();
    rx_rd = 0;
    chk("udf_flag", err_rx_udf, 1);
    chk("udf_level", rx_level, 0);
    clr_err = 1;
    tick();
    clr_err = 0;
    chk("udf_clr", err_rx_udf, 0);
    inject(8'h11, 1);
    inject(8'h22, 1);
    inject(8'h33, 1);
    tick(20);
    chk("sim_level3", rx_level, 3);
    chk("sim_head", rx_data, rx_exp.pop_front());
    inject(8'h44, 1);
    rx_rd = 1;
    tick();
    rx_rd = 0;
    chk("sim_level_same", rx_level, 3);
    chk("sim_urd", u_rd, 1);
    tick(3);
    for (int i = 0; i < 3; i++) cpu_pop("sim_order");
    for (int i = 0; i < DEPTH; i++) inject(8'hC0 + 8'(i), 1);
    tick(5 * DEPTH + 10);
    chk("hold_full", rx_level, DEPTH);
    rd_base = rd_pulses;
    inject(8'h7E, 1);
    tick(10);
    chk("hold_valid", u_valid, 1);
    chk("hold_no_rd", rd_pulses - rd_base, 0);
    chk("hold_level", rx_level, DEPTH);
    cpu_pop("hold_head");
    for (int i = 0; i < 3 && !u_rd; i++) tick();
    chk("hold_rd_pulse", u_rd, 1);
    tick();
    chk("hold_refill", rx_level, DEPTH);
    for (int i = 0; i < DEPTH; i++) cpu_pop("hold_order");
    chk("hold_empty", rx_valid, 0);
    force_busy = 1;
    rx_rd = 1;
    tick();
    rx_rd = 0;
    for (int i = 0; i < 5; i++) push_tx(8'h60 + 8'(i), 0);
    for (int i = 0; i < 5; i++) inject(8'h70 + 8'(i), 0);
    tick(30);
    chk("pre_rst_tx", tx_level, 5);
    chk("pre_rst_rx", rx_level, 5);
    chk("pre_rst_udf", err_rx_udf, 1);
    resetq = 0;
    #2;
    chk("mid_rst_levels", {tx_full, tx_level, rx_valid, rx_level}, 0);
    chk("mid_rst_strobes", {u_wr, u_rd, u_tx_data}, 0);
    chk("mid_rst_errs", {err_tx_ovf, err_rx_udf}, 0);
    tick(2);
    chk("mid_rst_hold", {u_wr, tx_level, rx_level}, 0);
    resetq = 1;
    force_busy = 0;
    base = tx_obs_n;
    tick(10);
    chk("post_rst_tx", tx_level, 0);
    chk("post_rst_rx", rx_valid, 0);
    chk("post_rst_no_wr", tx_obs_n - base, 0);
    chk("pulse_gaps", gap_bad, 0);
    chk("wr_after_idle", busy_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
